// File: rtl/cursor_pkg.sv
// cursor_pkg: shared constants for the cursor overlay.
//   cursor_mode_t   : cursor shape selector (off / crosshair / box / sprite)
//   SPRITE_DIM      : sprite width and height in pixels
//   OVERLAY_LATENCY : clocks from any input to the matching output
package cursor_pkg;

    typedef enum logic [1:0] {
        CURSOR_OFF    = 2'd0,
        CURSOR_CROSS  = 2'd1,
        CURSOR_BOX    = 2'd2,
        CURSOR_SPRITE = 2'd3
    } cursor_mode_t;

    localparam int SPRITE_DIM      = 16;
    localparam int OVERLAY_LATENCY = 2;

endpackage

// File: rtl/cursor_sprite_rom.sv
// cursor_sprite_rom: 16x16 1-bit arrow cursor, tip at the top-left corner.
// Purely combinational; bit n of the returned row is column n (bit 0 = leftmost).
//   row  in  4   sprite row (dy)
//   bits out 16  pixel mask of that row
module cursor_sprite_rom
    import cursor_pkg::*;
(
    input  logic [3:0]            row,
    output logic [SPRITE_DIM-1:0] bits
);

    // Rows 0..10 form the arrow head (a filled right triangle),
    // rows 11..15 the three-pixel-wide tail slanting down-right.
    always_comb begin
        bits = '0;
        case (row)
            4'd0:  bits = 16'h0001;
            4'd1:  bits = 16'h0003;
            4'd2:  bits = 16'h0007;
            4'd3:  bits = 16'h000F;
            4'd4:  bits = 16'h001F;
            4'd5:  bits = 16'h003F;
            4'd6:  bits = 16'h007F;
            4'd7:  bits = 16'h00FF;
            4'd8:  bits = 16'h01FF;
            4'd9:  bits = 16'h03FF;
            4'd10: bits = 16'h07FF;
            4'd11: bits = 16'h00E0;
            4'd12: bits = 16'h01C0;
            4'd13: bits = 16'h0380;
            4'd14: bits = 16'h0700;
            4'd15: bits = 16'h0E00;
            default: bits = '0;
        endcase
    end

endmodule

// File: rtl/cursor_overlay.sv
// cursor_overlay: draws a mouse cursor onto a VGA pixel stream.
// The cursor position and shape are latched once per frame on the rising
// edge of in_vsync so the cursor never tears. Every output, timing included,
// is exactly two pixel clocks behind its input.
// Build option: define CURSOR_SPRITE_EN to build the 16x16 arrow sprite for
// mode 3; without it mode 3 draws the crosshair.
// Ports:
//   clk_pixel, reset                   pixel clock, sync active-high reset
//   mouse_x, mouse_y, mouse_btn        raw mouse position and buttons
//   mode                               0 off, 1 crosshair, 2 box, 3 sprite
//   beam_x, beam_y                     coordinates of the incoming pixel
//   in_red/green/blue, in_h/vsync, in_blank     source stream
//   out_red/green/blue, out_h/vsync, out_blank  composited stream
module cursor_overlay
    import cursor_pkg::*;
#(
    parameter int C_x_bits       = 10,
    parameter int C_y_bits       = 10,
    parameter int C_h_visible    = 640,
    parameter int C_v_visible    = 480,
    parameter int C_color_bits   = 8,
    parameter int C_size         = 8,
    parameter int C_blink_frames = 0
) (
    input  logic                    clk_pixel,
    input  logic                    reset,
    input  logic [C_x_bits-1:0]     mouse_x,
    input  logic [C_y_bits-1:0]     mouse_y,
    input  logic [2:0]              mouse_btn,
    input  logic [1:0]              mode,
    input  logic [C_x_bits-1:0]     beam_x,
    input  logic [C_y_bits-1:0]     beam_y,
    input  logic [C_color_bits-1:0] in_red,
    input  logic [C_color_bits-1:0] in_green,
    input  logic [C_color_bits-1:0] in_blue,
    input  logic                    in_hsync,
    input  logic                    in_vsync,
    input  logic                    in_blank,
    output logic [C_color_bits-1:0] out_red,
    output logic [C_color_bits-1:0] out_green,
    output logic [C_color_bits-1:0] out_blue,
    output logic                    out_hsync,
    output logic                    out_vsync,
    output logic                    out_blank
);

    localparam logic [C_x_bits-1:0] X_MAX    = C_x_bits'(C_h_visible - 1);
    localparam logic [C_y_bits-1:0] Y_MAX    = C_y_bits'(C_v_visible - 1);
    localparam logic [C_x_bits-1:0] X_CENTER = C_x_bits'(C_h_visible / 2);
    localparam logic [C_y_bits-1:0] Y_CENTER = C_y_bits'(C_v_visible / 2);
    localparam logic signed [C_x_bits:0] SIZE_X = (C_x_bits + 1)'(C_size);
    localparam logic signed [C_y_bits:0] SIZE_Y = (C_y_bits + 1)'(C_size);

    function automatic logic [C_x_bits-1:0] clamp_x(input logic [C_x_bits-1:0] v);
        return (v > X_MAX) ? X_MAX : v;
    endfunction

    function automatic logic [C_y_bits-1:0] clamp_y(input logic [C_y_bits-1:0] v);
        return (v > Y_MAX) ? Y_MAX : v;
    endfunction

    logic [C_x_bits-1:0] cur_x;
    logic [C_y_bits-1:0] cur_y;
    cursor_mode_t        cur_mode;
    logic                vsync_rise;
    logic                blink_vis;

    logic [C_color_bits-1:0] red_p1, green_p1, blue_p1;
    logic                    hsync_p1, vsync_p1, blank_p1, draw_p1;
    logic [2:0]              btn_p1;

    // vsync_p1 doubles as the previous-cycle vsync for edge detection.
    assign vsync_rise = in_vsync & ~vsync_p1;

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            cur_x    <= X_CENTER;
            cur_y    <= Y_CENTER;
            cur_mode <= CURSOR_CROSS;
        end else if (vsync_rise) begin
            cur_x    <= clamp_x(mouse_x);
            cur_y    <= clamp_y(mouse_y);
            cur_mode <= cursor_mode_t'(mode);
        end
    end

    generate
        if (C_blink_frames > 0) begin : g_blink
            localparam int CNT_W = $clog2(2 * C_blink_frames) + 1;
            localparam logic [CNT_W-1:0] CNT_ON   = CNT_W'(C_blink_frames);
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * C_blink_frames - 1);
            logic [CNT_W-1:0] blink_cnt;

            // A pressed button parks the counter at the start of the "on" phase.
            always_ff @(posedge clk_pixel) begin
                if (reset || (|mouse_btn)) begin
                    blink_cnt <= '0;
                end else if (vsync_rise) begin
                    blink_cnt <= (blink_cnt == CNT_LAST) ? '0 : blink_cnt + 1'b1;
                end
            end

            assign blink_vis = (|mouse_btn) || (blink_cnt < CNT_ON);
        end else begin : g_no_blink
            assign blink_vis = 1'b1;
        end
    endgenerate

    // Offsets are one bit wider and signed so a cursor near 0 never wraps.
    logic signed [C_x_bits:0] beam_xs, cur_xs, dx, adx;
    logic signed [C_y_bits:0] beam_ys, cur_ys, dy, ady;
    logic                     cross_hit, box_hit, hit;

    assign beam_xs = {1'b0, beam_x};
    assign cur_xs  = {1'b0, cur_x};
    assign beam_ys = {1'b0, beam_y};
    assign cur_ys  = {1'b0, cur_y};

    always_comb begin
        dx  = beam_xs - cur_xs;
        dy  = beam_ys - cur_ys;
        adx = dx[C_x_bits] ? -dx : dx;
        ady = dy[C_y_bits] ? -dy : dy;
    end

    assign cross_hit = (beam_x == cur_x) || (beam_y == cur_y);
    assign box_hit   = (adx <= SIZE_X) && (ady <= SIZE_Y) &&
                       ((adx == SIZE_X) || (ady == SIZE_Y));

`ifdef CURSOR_SPRITE_EN
    localparam logic signed [C_x_bits:0] SPR_X = (C_x_bits + 1)'(SPRITE_DIM);
    localparam logic signed [C_y_bits:0] SPR_Y = (C_y_bits + 1)'(SPRITE_DIM);
    logic [SPRITE_DIM-1:0] sprite_row;
    logic                  sprite_hit;

    cursor_sprite_rom u_sprite_rom (
        .row  (dy[3:0]),
        .bits (sprite_row)
    );

    assign sprite_hit = !dx[C_x_bits] && (dx < SPR_X) &&
                        !dy[C_y_bits] && (dy < SPR_Y) &&
                        sprite_row[dx[3:0]];
`else
    logic sprite_hit;
    assign sprite_hit = cross_hit;
`endif

    always_comb begin
        hit = 1'b0;
        case (cur_mode)
            CURSOR_OFF:    hit = 1'b0;
            CURSOR_CROSS:  hit = cross_hit;
            CURSOR_BOX:    hit = box_hit;
            CURSOR_SPRITE: hit = sprite_hit;
            default:       hit = 1'b0;
        endcase
    end

    // Stage 1: hit decision registered alongside the delayed source pixel
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            red_p1   <= '0;
            green_p1 <= '0;
            blue_p1  <= '0;
            hsync_p1 <= 1'b0;
            vsync_p1 <= 1'b0;
            blank_p1 <= 1'b1;
            draw_p1  <= 1'b0;
            btn_p1   <= '0;
        end else begin
            red_p1   <= in_red;
            green_p1 <= in_green;
            blue_p1  <= in_blue;
            hsync_p1 <= in_hsync;
            vsync_p1 <= in_vsync;
            blank_p1 <= in_blank;
            draw_p1  <= hit & blink_vis & ~in_blank;
            btn_p1   <= mouse_btn;
        end
    end

    // No button gives white; otherwise each pressed button lights its channel.
    logic [C_color_bits-1:0] cursor_red, cursor_green, cursor_blue;
    logic                    no_btn;

    always_comb begin
        no_btn       = ~|btn_p1;
        cursor_red   = (no_btn || btn_p1[0]) ? '1 : '0;
        cursor_green = (no_btn || btn_p1[1]) ? '1 : '0;
        cursor_blue  = (no_btn || btn_p1[2]) ? '1 : '0;
    end

    // Stage 2: colour mux into the output registers
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            out_red   <= '0;
            out_green <= '0;
            out_blue  <= '0;
            out_hsync <= 1'b0;
            out_vsync <= 1'b0;
            out_blank <= 1'b1;
        end else begin
            out_red   <= draw_p1 ? cursor_red   : red_p1;
            out_green <= draw_p1 ? cursor_green : green_p1;
            out_blue  <= draw_p1 ? cursor_blue  : blue_p1;
            out_hsync <= hsync_p1;
            out_vsync <= vsync_p1;
            out_blank <= blank_p1;
        end
    end

endmodule

// File: tb/tb_cursor_overlay.sv
// tb_cursor_overlay: bench for cursor_overlay. Two instances share all inputs:
// dut (never blinks) and dut_blink (C_blink_frames = 2). A frame-level model
// predicts every output of both each cycle; directed tables and sequences
// cover latency, clamping, latch timing, box edges, buttons, blink and sprite.
// Honours CURSOR_SPRITE_EN the same way the design does.
module tb_cursor_overlay;

    localparam logic [23:0] WHITE = 24'hFFFFFF;
    localparam logic [23:0] PASS  = 24'h123456;
    localparam logic [26:0] RST_OUT = 27'h1;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] mouse_x, mouse_y, beam_x, beam_y;
    logic [2:0] mouse_btn;
    logic [1:0] mode;
    logic [7:0] in_red, in_green, in_blue;
    logic       in_hsync, in_vsync, in_blank;

    logic [7:0] o0_r, o0_g, o0_b, o1_r, o1_g, o1_b;
    logic       o0_hs, o0_vs, o0_bl, o1_hs, o1_vs, o1_bl;
    logic [26:0] act0, act1;

    assign act0 = {o0_r, o0_g, o0_b, o0_hs, o0_vs, o0_bl};
    assign act1 = {o1_r, o1_g, o1_b, o1_hs, o1_vs, o1_bl};

    always #5 clk = ~clk;

    cursor_overlay dut (
        .clk_pixel(clk), .reset(reset),
        .mouse_x(mouse_x), .mouse_y(mouse_y), .mouse_btn(mouse_btn), .mode(mode),
        .beam_x(beam_x), .beam_y(beam_y),
        .in_red(in_red), .in_green(in_green), .in_blue(in_blue),
        .in_hsync(in_hsync), .in_vsync(in_vsync), .in_blank(in_blank),
        .out_red(o0_r), .out_green(o0_g), .out_blue(o0_b),
        .out_hsync(o0_hs), .out_vsync(o0_vs), .out_blank(o0_bl)
    );

    cursor_overlay #(.C_blink_frames(2)) dut_blink (
        .clk_pixel(clk), .reset(reset),
        .mouse_x(mouse_x), .mouse_y(mouse_y), .mouse_btn(mouse_btn), .mode(mode),
        .beam_x(beam_x), .beam_y(beam_y),
        .in_red(in_red), .in_green(in_green), .in_blue(in_blue),
        .in_hsync(in_hsync), .in_vsync(in_vsync), .in_blank(in_blank),
        .out_red(o1_r), .out_green(o1_g), .out_blue(o1_b),
        .out_hsync(o1_hs), .out_vsync(o1_vs), .out_blank(o1_bl)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Model state: frame-latched cursor, blink frame counter, 2-deep output delay.
    int          m_cx, m_cy, m_mode, m_cnt;
    logic        m_prev_vs;
    logic [26:0] q1_0, q1_1, exp0, exp1;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic bit arrow_px(input int x, input int y);
        if (y <= 10) return x <= y;
        return (x >= y - 6) && (x <= y - 4);
    endfunction

    function automatic bit model_hit(input int bx, input int by, input int cx, input int cy, input int md);
        int ddx, ddy;
        ddx = bx - cx;
        ddy = by - cy;
        case (md)
            0: return 1'b0;
            1: return (bx == cx) || (by == cy);
            2: return (iabs(ddx) <= 8) && (iabs(ddy) <= 8) && ((iabs(ddx) == 8) || (iabs(ddy) == 8));
            default: begin
`ifdef CURSOR_SPRITE_EN
                return (ddx >= 0) && (ddx < 16) && (ddy >= 0) && (ddy < 16) && arrow_px(ddx, ddy);
`else
                return (bx == cx) || (by == cy);
`endif
            end
        endcase
    endfunction

    function automatic logic [26:0] model_pixel(input int blink_frames, input int cnt);
        bit vis, draw;
        logic [7:0] r, g, b;
        vis  = (blink_frames == 0) || (mouse_btn != 3'b000) || (cnt < blink_frames);
        draw = vis && !in_blank && model_hit(int'(beam_x), int'(beam_y), m_cx, m_cy, m_mode);
        if (draw) begin
            r = (mouse_btn == 3'b000 || mouse_btn[0]) ? 8'hFF : 8'h00;
            g = (mouse_btn == 3'b000 || mouse_btn[1]) ? 8'hFF : 8'h00;
            b = (mouse_btn == 3'b000 || mouse_btn[2]) ? 8'hFF : 8'h00;
        end else begin
            r = in_red;
            g = in_green;
            b = in_blue;
        end
        return {r, g, b, in_hsync, in_vsync, in_blank};
    endfunction

    // Advance the model by one clock edge with the inputs currently driven.
    task automatic model_edge();
        bit rise;
        if (reset) begin
            q1_0 = RST_OUT; q1_1 = RST_OUT; exp0 = RST_OUT; exp1 = RST_OUT;
            m_cx = 320; m_cy = 240; m_mode = 1; m_cnt = 0; m_prev_vs = 1'b0;
        end else begin
            exp0 = q1_0;
            exp1 = q1_1;
            q1_0 = model_pixel(0, 0);
            q1_1 = model_pixel(2, m_cnt);
            rise = in_vsync && !m_prev_vs;
            m_prev_vs = in_vsync;
            if (rise) begin
                m_cx   = (int'(mouse_x) > 639) ? 639 : int'(mouse_x);
                m_cy   = (int'(mouse_y) > 479) ? 479 : int'(mouse_y);
                m_mode = int'(mode);
            end
            if (mouse_btn != 3'b000) m_cnt = 0;
            else if (rise) m_cnt = (m_cnt + 1) % 4;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check("model_dut", 32'(act0), 32'(exp0));
        check("model_dut_blink", 32'(act1), 32'(exp1));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic vsync_pulse();
        in_vsync = 1'b0; tick();
        in_vsync = 1'b1; tick();
        in_vsync = 1'b0; tick();
    endtask

    typedef struct {
        logic [9:0]  mx, my;
        logic [1:0]  md;
        logic [2:0]  btn;
        logic [9:0]  bx, by;
        logic        blank;
        logic [23:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input int mx, input int my, input int md, input int btn,
                           input int bx, input int by, input bit blank, input logic [23:0] exp);
        vec_t v;
        v.mx = 10'(mx); v.my = 10'(my); v.md = 2'(md); v.btn = 3'(btn);
        v.bx = 10'(bx); v.by = 10'(by); v.blank = blank; v.exp = exp;
        vecs.push_back(v);
    endtask

    int blink_exp[5] = '{1, 1, 0, 0, 1};

    initial begin
        reset = 1'b1;
        mouse_x = 10'd0; mouse_y = 10'd0; mouse_btn = 3'b000; mode = 2'd0;
        beam_x = 10'd10; beam_y = 10'd10;
        in_red = 8'h00; in_green = 8'h00; in_blue = 8'h00;
        in_hsync = 1'b0; in_vsync = 1'b0; in_blank = 1'b1;

        // Reset: colours 0, syncs 0, blank 1.
        in_red = 8'hAA; in_blank = 1'b0; in_hsync = 1'b1;
        ticks(3);
        check("reset_out", 32'(act0), 32'(RST_OUT));
        reset = 1'b0;
        in_red = 8'h00; in_blank = 1'b1; in_hsync = 1'b0;
        ticks(3);

        // Latency: one-cycle hsync/blank/colour event emerges exactly two edges later.
        in_hsync = 1'b1; in_blank = 1'b0; in_red = 8'hA5;
        tick();
        check("lat_edge1_hsync", 32'(o0_hs), 32'd0);
        in_hsync = 1'b0; in_blank = 1'b1; in_red = 8'h00;
        tick();
        check("lat_edge2_hsync", 32'(o0_hs), 32'd1);
        check("lat_edge2_blank", 32'(o0_bl), 32'd0);
        check("lat_edge2_red", 32'(o0_r), 32'hA5);
        tick();
        check("lat_edge3_hsync", 32'(o0_hs), 32'd0);
        check("lat_edge3_blank", 32'(o0_bl), 32'd1);

        // Latch timing: mid-frame mouse move is ignored until next vsync edge.
        mode = 2'd1; mouse_x = 10'd100; mouse_y = 10'd400;
        vsync_pulse();
        in_red = 8'h12; in_green = 8'h34; in_blue = 8'h56; in_blank = 1'b0;
        beam_x = 10'd100; beam_y = 10'd7;
        mouse_x = 10'd200;
        ticks(3);
        check("latch_old_x", 32'({o0_r, o0_g, o0_b}), 32'(WHITE));
        beam_x = 10'd200;
        ticks(3);
        check("latch_new_x_early", 32'({o0_r, o0_g, o0_b}), 32'(PASS));
        in_blank = 1'b1;
        vsync_pulse();
        in_blank = 1'b0;
        ticks(3);
        check("latch_new_x", 32'({o0_r, o0_g, o0_b}), 32'(WHITE));

        // Directed vectors.
        add_vec(700, 500, 1, 0, 639, 100, 1'b0, WHITE);
        add_vec(700, 500, 1, 0, 638, 100, 1'b0, PASS);
        add_vec(700, 500, 1, 0, 200, 479, 1'b0, WHITE);
        add_vec(3, 3, 2, 0, 11, 3, 1'b0, WHITE);
        add_vec(3, 3, 2, 0, 3, 11, 1'b0, WHITE);
        add_vec(3, 3, 2, 0, 639, 3, 1'b0, PASS);
        add_vec(3, 3, 2, 0, 3, 479, 1'b0, PASS);
        add_vec(3, 3, 2, 0, 7, 7, 1'b0, PASS);
        add_vec(100, 100, 0, 0, 100, 100, 1'b0, PASS);
        add_vec(50, 60, 1, 1, 50, 0, 1'b0, 24'hFF0000);
        add_vec(50, 60, 1, 6, 0, 60, 1'b0, 24'h00FFFF);
        add_vec(50, 60, 1, 0, 50, 60, 1'b1, PASS);
        add_vec(100, 100, 3, 0, 100, 100, 1'b0, WHITE);
`ifdef CURSOR_SPRITE_EN
        add_vec(100, 100, 3, 0, 99, 100, 1'b0, PASS);
        add_vec(100, 100, 3, 0, 105, 110, 1'b0, WHITE);
        add_vec(100, 100, 3, 0, 112, 101, 1'b0, PASS);
`else
        add_vec(100, 100, 3, 0, 99, 100, 1'b0, WHITE);
        add_vec(100, 100, 3, 0, 105, 110, 1'b0, PASS);
`endif

        foreach (vecs[i]) begin
            mouse_x = vecs[i].mx; mouse_y = vecs[i].my; mode = vecs[i].md;
            mouse_btn = vecs[i].btn; in_blank = 1'b1;
            vsync_pulse();
            beam_x = vecs[i].bx; beam_y = vecs[i].by; in_blank = vecs[i].blank;
            in_red = 8'h12; in_green = 8'h34; in_blue = 8'h56;
            ticks(3);
            check($sformatf("vec%0d", i), 32'({o0_r, o0_g, o0_b}), 32'(vecs[i].exp));
        end

        // Blink (dut_blink): visible, visible, hidden, hidden, visible; then button forces red.
        mouse_btn = 3'b000; mode = 2'd1; mouse_x = 10'd320; mouse_y = 10'd240;
        reset = 1'b1; ticks(2); reset = 1'b0;
        beam_x = 10'd320; beam_y = 10'd5;
        for (int f = 0; f < 5; f++) begin
            in_blank = 1'b1;
            if (f > 0) vsync_pulse();
            in_blank = 1'b0;
            ticks(3);
            check($sformatf("blink_f%0d", f), 32'({o1_r, o1_g, o1_b}),
                  32'((blink_exp[f] != 0) ? WHITE : PASS));
        end
        mouse_btn = 3'b001;
        for (int f = 0; f < 4; f++) begin
            in_blank = 1'b1;
            vsync_pulse();
            in_blank = 1'b0;
            ticks(3);
            check($sformatf("blink_btn_f%0d", f), 32'({o1_r, o1_g, o1_b}), 32'h00FF0000);
        end

        // Randomized traffic, every cycle checked against the model.
        for (int n = 0; n < 4000; n++) begin
            int bx, by;
            reset     = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 39) == 0) in_vsync = ~in_vsync;
            in_hsync  = ($urandom_range(0, 7) == 0);
            in_blank  = ($urandom_range(0, 5) == 0);
            mouse_x   = 10'($urandom_range(0, 1023));
            mouse_y   = 10'($urandom_range(0, 1023));
            mode      = 2'($urandom_range(0, 3));
            mouse_btn = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
            if ($urandom_range(0, 1) == 0) begin
                bx = m_cx + int'($urandom_range(0, 40)) - 20;
                by = m_cy + int'($urandom_range(0, 40)) - 20;
                bx = (bx < 0) ? 0 : bx;
                by = (by < 0) ? 0 : by;
            end else begin
                bx = int'($urandom_range(0, 1023));
                by = int'($urandom_range(0, 1023));
            end
            beam_x   = 10'(bx);
            beam_y   = 10'(by);
            in_red   = 8'($urandom);
            in_green = 8'($urandom);
            in_blue  = 8'($urandom);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/cursor_overlay.md
Name: cursor_overlay

Overview:
- Pixel-domain overlay that draws a mouse cursor onto an incoming VGA stream (RGB, sync, blank) ahead of vga2dvid.
- Parametrised successor to the fixed crosshair drawn in the PS/2 mouse DVI tops.
- Adds screen-size clamping, tear-free per-frame position latching, selectable cursor shapes, button-coloured cursor, blink, and a fixed pipeline latency with syncs delayed to match.

Parameters:
- C_x_bits, 10, width of mouse_x and beam_x
- C_y_bits, 10, width of mouse_y and beam_y
- C_h_visible, 640, visible width; cursor x clamped to C_h_visible-1
- C_v_visible, 480, visible height; cursor y clamped to C_v_visible-1
- C_color_bits, 8, per-channel colour width
- C_size, 8, box half-size in pixels
- C_blink_frames, 0, frames on and frames off; 0 = never blink

Ports:
- clk_pixel  in  1  pixel clock; the only clock
- reset  in  1  synchronous, active-high
- mouse_x  in  C_x_bits  raw mouse x position
- mouse_y  in  C_y_bits  raw mouse y position
- mouse_btn  in  3  [0] left, [1] right, [2] middle
- mode  in  2  cursor shape: 0 off, 1 crosshair, 2 box, 3 sprite
- beam_x  in  C_x_bits  current pixel x
- beam_y  in  C_y_bits  current pixel y
- in_red, in_green, in_blue  in  C_color_bits each  source pixel
- in_hsync, in_vsync, in_blank  in  1 each  source timing
- out_red, out_green, out_blue  out  C_color_bits each  composited pixel
- out_hsync, out_vsync, out_blank  out  1 each  timing delayed to match pixels

Behaviour:
- Reset (synchronous, active-high):
  - Outputs: all colour outputs 0, out_hsync 0, out_vsync 0, out_blank 1.
  - Internal: cur_x = C_h_visible/2, cur_y = C_v_visible/2, latched mode = 1, blink counter 0, all pipeline registers cleared.
  - Reset asserted mid-frame gives reset outputs on the next edge; the latched position is held until the next vsync edge after reset release.
- Frame latch, on in_vsync rising edge (detected against the previous registered in_vsync):
  - cur_x = min(mouse_x, C_h_visible-1); cur_y = min(mouse_y, C_v_visible-1); mode is latched.
  - Changes to mouse position or mode mid-frame have no effect until the next edge.
- Blink (C_blink_frames > 0):
  - Counter increments on each vsync edge and wraps after 2*C_blink_frames-1.
  - Cursor is visible while counter < C_blink_frames.
  - Any mouse_btn bit high forces the cursor visible and holds the counter at 0.
  - C_blink_frames = 0 means always visible.
- Pipeline: latency is exactly 2 cycles for every output, syncs and blank included.
  - Stage 1: signed dx = beam_x - cur_x (C_x_bits+1 bits) and dy likewise, then the hit flag.
  - Stage 2: colour mux.
- Hit rules:
  - mode 0: never a hit.
  - mode 1 (crosshair): beam_x == cur_x or beam_y == cur_y.
  - mode 2 (box outline): |dx| <= C_size and |dy| <= C_size, and (|dx| == C_size or |dy| == C_size).
  - mode 3 (sprite): 0 <= dx < 16 and 0 <= dy < 16 and sprite bit [dy][dx] is set; cur_x/cur_y is the sprite's top-left corner.
  - No wrap-around: a cursor near x = 0 never draws at the right edge, and likewise for y.
- Colour:
  - Output pixel is the cursor colour when hit, visible and blank is low; otherwise the delayed input pixel passes through unchanged.
  - No buttons pressed: cursor is white (all channels all-ones).
  - Any button pressed: red = all-ones if btn[0], green = all-ones if btn[1], blue = all-ones if btn[2], otherwise 0.

Optional Feature:
- CURSOR_SPRITE_EN defined: mode 3 draws a 16x16 1-bit arrow (tip at top-left).
- Undefined: no sprite ROM is built, and mode 3 behaves exactly as mode 1. Latency is unchanged.

Decomposition:
- Package cursor_pkg holds:
  - mode constants CURSOR_OFF/CROSS/BOX/SPRITE
  - SPRITE_DIM = 16
  - OVERLAY_LATENCY = 2
- Sub-module cursor_sprite_rom: combinational 16x16 lookup (row address dy[3:0], returns 16-bit row), read in stage 1; instantiated only under CURSOR_SPRITE_EN.

Test Plan:
- Latency: after reset, drive an in_hsync pulse and blank toggles with mode 0 -> out_hsync, out_blank and the passthrough pixels appear exactly 2 clocks later; during reset out_blank = 1 and colours = 0.
- Clamp: mouse_x = 700, mouse_y = 500, mode 1, vsync edge -> vertical white line at beam_x = 639, horizontal line at beam_y = 479.
- Latch timing: mouse_x changes 100 -> 200 mid-frame -> line stays at x = 100 until the next vsync edge, then moves to x = 200.
- Box at edge: cur = (3, 3), C_size = 8, mode 2 -> outline pixels at (11, 3) and (3, 11); no pixel at x >= 635 or y >= 475.
- Buttons and blink: C_blink_frames = 2, no buttons -> visible, visible, hidden, hidden over 4 frames; btn = 3'b001 -> red cursor (FF, 00, 00), always visible.
- Sprite: with CURSOR_SPRITE_EN, cur = (100, 100), mode 3 -> pixel (100, 100) white, (99, 100) passthrough; without the macro -> crosshair drawn instead.
